// File: rtl/sync_fifo_fwft_ctrl_pkg.sv
// Shared types and elaboration helpers for the single-clock FWFT FIFO controller.
// Holds the output-buffer state encoding and the address-width function.
package sync_fifo_fwft_ctrl_pkg;

    // The encoding doubles as the buffer word count (0, 1 or 2).
    typedef enum logic [1:0] {
        OBUF_EMPTY = 2'd0,
        OBUF_ONE   = 2'd1,
        OBUF_TWO   = 2'd2
    } obuf_state_e;

    // Ceiling log2 that never returns 0, so a 1-word RAM still gets a 1-bit address.
    function automatic int clog2s(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_ctrl_if.sv
// Bundle between the FIFO controller (slave) and its parent wrapper (master),
// which owns both the user push/pop side and the attached fifomem RAM.
interface sync_fifo_fwft_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
);
    import sync_fifo_fwft_ctrl_pkg::*;

    localparam int ADDR_WIDTH = clog2s(FIFO_DEPTH);

    logic                  wr_en_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  full_o;
    logic                  almost_full_o;
    logic                  overflow_o;
    logic                  rd_valid_o;
    logic                  rd_ready_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic [ADDR_WIDTH+1:0] fill_o;

    logic                  mem_wr_en_o;
    logic [ADDR_WIDTH-1:0] mem_wr_addr_o;
    logic [DATA_WIDTH-1:0] mem_wr_data_o;
    logic                  mem_rd_en_o;
    logic [ADDR_WIDTH-1:0] mem_rd_addr_o;
    logic [DATA_WIDTH-1:0] mem_rd_data_i;

    modport slave (
        input  wr_en_i, wr_data_i, rd_ready_i, mem_rd_data_i,
        output full_o, almost_full_o, overflow_o, rd_valid_o, rd_data_o, fill_o,
        output mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o, mem_rd_en_o, mem_rd_addr_o
    );

    modport master (
        output wr_en_i, wr_data_i, rd_ready_i, mem_rd_data_i,
        input  full_o, almost_full_o, overflow_o, rd_valid_o, rd_data_o, fill_o,
        input  mem_wr_en_o, mem_wr_addr_o, mem_wr_data_o, mem_rd_en_o, mem_rd_addr_o
    );

endinterface

// File: rtl/sync_fifo_fwft_ctrl_skid_buf.sv
// Two-entry output buffer (head + skid) that absorbs the RAM's registered read data
// and presents the head word first-word-fall-through.
module sync_fifo_fwft_ctrl_skid_buf
    import sync_fifo_fwft_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [1:0]            count,
    output logic [DATA_WIDTH-1:0] head
);

    obuf_state_e           state;
    logic [DATA_WIDTH-1:0] skid;

    // NOTE: head/skid are reset only so rd_data_o reads 0 out of reset; the RAM itself is never cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= OBUF_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            case (state)
                OBUF_EMPTY: begin
                    if (capture) begin
                        head  <= cap_data;
                        state <= OBUF_ONE;
                    end
                end
                OBUF_ONE: begin
                    if (capture && pop) begin
                        head <= cap_data;
                    end else if (capture) begin
                        skid  <= cap_data;
                        state <= OBUF_TWO;
                    end else if (pop) begin
                        state <= OBUF_EMPTY;
                    end
                end
                OBUF_TWO: begin
                    if (pop) begin
                        head <= skid;
                        if (capture) begin
                            skid <= cap_data;
                        end else begin
                            state <= OBUF_ONE;
                        end
                    end
                end
                default: state <= OBUF_EMPTY;
            endcase
        end
    end

    assign valid = (state != OBUF_EMPTY);
    assign count = state;

    // The issue rule in the parent never lets a word land on a full buffer.
    no_capture_when_two: assert property (@(posedge clk) disable iff (!rst_n)
        !(capture && !pop && state == OBUF_TWO));

endmodule

// File: rtl/sync_fifo_fwft_ctrl.sv
// Single-clock pointer/flag controller for an external fifomem RAM, converting its
// 1-cycle read latency into a full-throughput first-word-fall-through output.
module sync_fifo_fwft_ctrl
    import sync_fifo_fwft_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AFULL_THR  = 12
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    sync_fifo_fwft_ctrl_if.slave bus
);

    localparam int ADDR_WIDTH = clog2s(FIFO_DEPTH);
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam int FILL_WIDTH = ADDR_WIDTH + 2;
    localparam logic [PTR_WIDTH-1:0]  FULL_LVL  = PTR_WIDTH'(FIFO_DEPTH);
    localparam logic [FILL_WIDTH-1:0] AFULL_LVL = FILL_WIDTH'(AFULL_THR);

    logic [PTR_WIDTH-1:0]  wptr, rptr, wptr_nxt, rptr_nxt;
    logic [PTR_WIDTH-1:0]  ram_cnt, ram_cnt_nxt;
    logic [FILL_WIDTH-1:0] fill, fill_nxt;
    logic                  full, almost_full, overflow, inflight;
    logic                  push, pop, issue, obuf_valid;
    logic [1:0]            obuf_cnt;
    logic [2:0]            obuf_load;
    logic [DATA_WIDTH-1:0] head;

    // The extra pointer MSB tells a full RAM (cnt == depth) from an empty one.
    assign ram_cnt   = wptr - rptr;
    assign push      = bus.wr_en_i & ~full;
    assign pop       = obuf_valid & bus.rd_ready_i;

    // Words the output buffer will hold after this edge, before counting a new issue.
    assign obuf_load = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = (ram_cnt != '0) && (obuf_load < 3'd2);

    assign wptr_nxt    = wptr + {{ADDR_WIDTH{1'b0}}, push};
    assign rptr_nxt    = rptr + {{ADDR_WIDTH{1'b0}}, issue};
    assign ram_cnt_nxt = wptr_nxt - rptr_nxt;

    // Words only move between RAM, flight and buffer internally, so only push/pop change the total.
    assign fill_nxt = fill + FILL_WIDTH'(push) - FILL_WIDTH'(pop);

    // NOTE: clocked state uses non-blocking (<=) so every flop samples the pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr        <= '0;
            rptr        <= '0;
            inflight    <= 1'b0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            fill        <= '0;
        end else begin
            wptr        <= wptr_nxt;
            rptr        <= rptr_nxt;
            inflight    <= issue;
            full        <= (ram_cnt_nxt == FULL_LVL);
            almost_full <= (fill_nxt >= AFULL_LVL);
            overflow    <= bus.wr_en_i & full;
            fill        <= fill_nxt;
        end
    end

    sync_fifo_fwft_ctrl_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk      (clk_i),
        .rst_n    (rstn_i),
        .capture  (inflight),
        .cap_data (bus.mem_rd_data_i),
        .pop      (pop),
        .valid    (obuf_valid),
        .count    (obuf_cnt),
        .head     (head)
    );

    assign bus.mem_wr_en_o   = push;
    assign bus.mem_wr_addr_o = wptr[ADDR_WIDTH-1:0];
    assign bus.mem_wr_data_o = bus.wr_data_i;
    assign bus.mem_rd_en_o   = issue;
    assign bus.mem_rd_addr_o = rptr[ADDR_WIDTH-1:0];

    assign bus.full_o        = full;
    assign bus.almost_full_o = almost_full;
    assign bus.overflow_o    = overflow;
    assign bus.rd_valid_o    = obuf_valid;
    assign bus.rd_data_o     = head;
    assign bus.fill_o        = fill;

endmodule

// File: tb/tb_sync_fifo_fwft_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus a random
// phase, all compared every cycle against a queue-based FIFO model.
`timescale 1ns/1ps
module tb_sync_fifo_fwft_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    sync_fifo_fwft_ctrl_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    sync_fifo_fwft_ctrl #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .AFULL_THR  (AFULL)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    // fifomem stand-in: synchronous write, registered read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_wr_en_o) ram[bus.mem_wr_addr_o] <= bus.mem_wr_data_o;
        if (bus.mem_rd_en_o) bus.mem_rd_data_i <= ram[bus.mem_rd_addr_o];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted word sits in one queue in arrival order; three
    // counters say how many of them are in RAM, on the RAM read port, and in the output buffer.
    logic [DW-1:0] mq[$];
    int   n_ram, n_fly, n_buf;
    logic m_ovf;
    logic e_full, e_valid, acc, pp, iss;

    always @(negedge clk) begin
        if (!rstn) begin
            mq.delete();
            n_ram = 0; n_fly = 0; n_buf = 0; m_ovf = 1'b0;
            check("rst_valid", bus.rd_valid_o, 0);
            check("rst_full", bus.full_o, 0);
            check("rst_afull", bus.almost_full_o, 0);
            check("rst_ovf", bus.overflow_o, 0);
            check("rst_fill", bus.fill_o, 0);
            check("rst_data", bus.rd_data_o, 0);
            check("rst_mem_rd_en", bus.mem_rd_en_o, 0);
        end else begin
            e_full  = (n_ram == DEPTH);
            e_valid = (n_buf > 0);
            check("valid", bus.rd_valid_o, e_valid);
            if (e_valid) check("data", bus.rd_data_o, mq[0]);
            check("full", bus.full_o, e_full);
            check("afull", bus.almost_full_o, mq.size() >= AFULL);
            check("fill", bus.fill_o, mq.size());
            check("ovf", bus.overflow_o, m_ovf);
            check("mem_wr_en", bus.mem_wr_en_o, bus.wr_en_i && !e_full);

            acc   = bus.wr_en_i && !e_full;
            pp    = e_valid && bus.rd_ready_i;
            iss   = (n_ram > 0) && (n_buf + n_fly - int'(pp) < 2);
            m_ovf = bus.wr_en_i && e_full;
            if (pp)  void'(mq.pop_front());
            if (acc) mq.push_back(bus.wr_data_i);
            n_buf = n_buf + n_fly - int'(pp);
            n_fly = int'(iss);
            n_ram = n_ram + int'(acc) - int'(iss);
        end
    end

    task automatic drive(input logic we, input logic [DW-1:0] d, input logic rr);
        @(posedge clk);
        #1;
        bus.wr_en_i    = we;
        bus.wr_data_i  = d;
        bus.rd_ready_i = rr;
    endtask

    task automatic drive_obs(input logic we, input logic [DW-1:0] d, input logic rr);
        drive(we, d, rr);
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        drive(1'b0, '0, 1'b1);
        while (bus.fill_o != 0 && n < 60) begin
            drive(1'b0, '0, 1'b1);
            n++;
        end
        check(name, bus.fill_o, 0);
        drive(1'b0, '0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] got[$];
    int next_word, cyc;
    logic rr;
    int pw, pr;

    initial begin
        rstn = 1'b1;
        bus.wr_en_i = 1'b0; bus.wr_data_i = '0; bus.rd_ready_i = 1'b0;
        #1 rstn = 1'b0;
        #1;
        check("init_valid", bus.rd_valid_o, 0);
        check("init_fill", bus.fill_o, 0);
        check("init_full", bus.full_o, 0);
        check("init_mem_wr_en", bus.mem_wr_en_o, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Latency: first word visible three cycles after it is presented.
        drive_obs(1'b1, 8'h01, 1'b1);
        check("lat_c0_valid", bus.rd_valid_o, 0);
        check("lat_c0_mem_wr_en", bus.mem_wr_en_o, 1);
        drive_obs(1'b1, 8'h02, 1'b1);
        check("lat_c1_valid", bus.rd_valid_o, 0);
        drive_obs(1'b1, 8'h03, 1'b1);
        check("lat_c2_valid", bus.rd_valid_o, 0);
        drive_obs(1'b0, 8'h00, 1'b1);
        check("lat_c3_valid", bus.rd_valid_o, 1);
        check("lat_c3_data", bus.rd_data_o, 8'h01);
        drive_obs(1'b0, 8'h00, 1'b1);
        check("lat_c4_data", bus.rd_data_o, 8'h02);
        drive_obs(1'b0, 8'h00, 1'b1);
        check("lat_c5_data", bus.rd_data_o, 8'h03);
        drive_obs(1'b0, 8'h00, 1'b1);
        check("lat_c6_valid", bus.rd_valid_o, 0);
        check("lat_c6_fill", bus.fill_o, 0);

        // Fill to the brim: 16 words leave two in the output buffer, 18 is full.
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h10 + i), 1'b0);
        drive_obs(1'b0, 8'h00, 1'b0);
        check("f16_full", bus.full_o, 0);
        check("f16_fill", bus.fill_o, 16);
        drive(1'b1, 8'h20, 1'b0);
        drive(1'b1, 8'h21, 1'b0);
        drive_obs(1'b1, 8'hEE, 1'b0);
        check("f18_full", bus.full_o, 1);
        check("f18_fill", bus.fill_o, 18);
        check("f19_mem_wr_en", bus.mem_wr_en_o, 0);
        drive_obs(1'b0, 8'h00, 1'b0);
        check("f19_ovf", bus.overflow_o, 1);
        check("f19_fill", bus.fill_o, 18);
        drive_obs(1'b0, 8'h00, 1'b0);
        check("f19_ovf_clear", bus.overflow_o, 0);
        got.delete();
        for (int i = 0; i < 30; i++) begin
            drive_obs(1'b0, 8'h00, 1'b1);
            if (bus.rd_valid_o) got.push_back(bus.rd_data_o);
        end
        check("full_drain_count", got.size(), 18);
        for (int i = 0; i < got.size() && i < 18; i++) check("full_drain_word", got[i], 8'h10 + i);
        drive(1'b0, 8'h00, 1'b0);

        // Almost-full threshold crossing in both directions.
        for (int i = 0; i < 11; i++) drive(1'b1, 8'(i), 1'b0);
        drive_obs(1'b1, 8'd11, 1'b0);
        check("af11_fill", bus.fill_o, 11);
        check("af11_afull", bus.almost_full_o, 0);
        drive_obs(1'b0, 8'h00, 1'b0);
        check("af12_fill", bus.fill_o, 12);
        check("af12_afull", bus.almost_full_o, 1);
        drive_obs(1'b0, 8'h00, 1'b1);
        check("af12_valid", bus.rd_valid_o, 1);
        drive_obs(1'b0, 8'h00, 1'b0);
        check("af_pop_fill", bus.fill_o, 11);
        check("af_pop_afull", bus.almost_full_o, 0);
        drain("af_drain");

        // 40-word stream with rd_ready toggling; writer respects full_o.
        got.delete();
        next_word = 0;
        cyc = 0;
        while (got.size() < 40 && cyc < 400) begin
            rr = ((cyc % 2) == 0);
            drive(next_word < 40, 8'(next_word), rr);
            if (next_word < 40 && !bus.full_o) next_word++;
            @(negedge clk);
            if (bus.rd_valid_o && bus.rd_ready_i) got.push_back(bus.rd_data_o);
            cyc++;
        end
        check("stream_count", got.size(), 40);
        for (int i = 0; i < got.size(); i++) check("stream_word", got[i], i);
        drive(1'b0, 8'h00, 1'b0);
        drain("stream_drain");

        // Steady push+pop at fill 5 for 64 cycles: pointers wrap twice.
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h50 + i), 1'b0);
        repeat (4) drive(1'b0, 8'h00, 1'b0);
        got.delete();
        for (int i = 0; i < 64; i++) begin
            drive_obs(1'b1, 8'(8'h60 + i), 1'b1);
            check("wrap_fill", bus.fill_o, 5);
            if (bus.rd_valid_o) got.push_back(bus.rd_data_o);
        end
        check("wrap_count", got.size(), 64);
        for (int i = 0; i < got.size(); i++)
            check("wrap_word", got[i], (i < 5) ? (8'h50 + i) : (8'h60 + i - 5));
        drain("wrap_drain");

        // Asynchronous reset with nine words queued.
        for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'h30 + i), 1'b0);
        drive_obs(1'b0, 8'h00, 1'b0);
        check("pre_rst_fill", bus.fill_o, 9);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("async_valid", bus.rd_valid_o, 0);
        check("async_full", bus.full_o, 0);
        check("async_afull", bus.almost_full_o, 0);
        check("async_ovf", bus.overflow_o, 0);
        check("async_fill", bus.fill_o, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        drive_obs(1'b1, 8'hAA, 1'b0);
        cyc = 0;
        drive_obs(1'b0, 8'h00, 1'b0);
        while (!bus.rd_valid_o && cyc < 10) begin
            drive_obs(1'b0, 8'h00, 1'b0);
            cyc++;
        end
        check("post_rst_valid", bus.rd_valid_o, 1);
        check("post_rst_data", bus.rd_data_o, 8'hAA);
        drain("post_rst_drain");

        // Random traffic in segments with differing push/pop pressure.
        for (int seg = 0; seg < 15; seg++) begin
            pw = $urandom_range(10, 95);
            pr = $urandom_range(10, 95);
            for (int i = 0; i < 200; i++) begin
                drive($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr);
            end
        end
        drain("rand_drain");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
